spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Parametrised SPI slave that bridges an external SPI master to a generic internal register port.
- Supports burst read and burst write with auto-incrementing address, configurable word and address widths, and selectable clock polarity.
- Sits between the SPI pins and the register file. Replaces hard-wired per-register muxing with a rd/wr port that the register file decodes.

Parameters:
- DATA_W, 16, SPI word width and register data width (≥ ADDR_W+2, ≥ 8).
- ADDR_W, 10, register address width; address space 2^ADDR_W words.
- ID_WORD, 16'h4A53, value shifted out on MISO during the command word; zero-extended or truncated to DATA_W.
- CPOL, 0, SPI_CLK idle level; 1 inverts SPI_CLK at the input. Clock phase is always: sample on leading edge, drive on trailing edge.

Ports:
- SYS_CLK  in  1  system clock; all logic on its rising edge.
- SYS_RST_N  in  1  asynchronous active-low reset.
- SPI_CLK  in  1  SPI clock, asynchronous to SYS_CLK.
- SSEL  in  1  slave select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data, MSB first.
- rd_en  out  1  one-cycle read request.
- rd_addr  out  ADDR_W  read address, valid with rd_en.
- rd_data  in  DATA_W  read data, valid exactly 1 SYS_CLK after rd_en.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  write address, valid with wr_en.
- wr_data  out  DATA_W  write data, valid with wr_en.
- busy  out  1  high while a frame is active.
- frame_abort  out  1  one-cycle pulse when SSEL deasserts with a partial word.

Behaviour:
- Input synchronisation:
  - SPI_CLK, SSEL and MOSI pass through 2-FF synchronisers plus one edge-detect register.
  - Required ratio: SCK half-period ≥ 6 SYS_CLK cycles.
- Frame and word timing:
  - A frame is SSEL low; busy mirrors synchronised SSEL active.
  - Word = DATA_W bits; bitcnt counts leading edges and wraps 0..DATA_W-1.
  - MOSI is sampled on the leading edge.
  - The shift register shifts MISO on trailing edges after bits 1..DATA_W-1 of each word. There is no shift on the trailing edge after bit DATA_W (word boundary).
- Command word (first word of every frame):
  - [DATA_W-1:DATA_W-2] = op: 2'b10 read burst, 2'b01 write burst, 2'b00/2'b11 no-op.
  - [ADDR_W-1:0] = start address; other bits ignored.
- States: IDLE, CMD, RD, WR, SKIP.
  - IDLE→CMD: SSEL falling. Shift register loads ID_WORD and its MSB drives MISO.
  - CMD→RD on op 10: in the cycle after the last command bit is sampled, assert rd_en with rd_addr = start address. Load rd_data into the shift register on the following cycle; MISO = new MSB.
  - CMD→WR on op 01: the address register loads the start address. MISO drives 0 for the rest of the frame.
  - CMD→SKIP on any other op: MOSI is ignored, MISO = 0.
  - RD: at every word boundary, increment the address, issue rd_en for it, and load the result as for the first word. Data words received on MOSI in RD are ignored. rd_en fires one word ahead, so the final fetch of a burst is speculative and harmless.
  - WR: the cycle after each complete data word, pulse wr_en with wr_addr = current address and wr_data = received word, then increment the address.
  - Any state→IDLE on SSEL rising. If bitcnt ≠ 0, pulse frame_abort and discard the partial word; no wr_en is issued for it.
- Address arithmetic:
  - Increment is modulo 2^ADDR_W: the all-ones address wraps to 0.
  - The first data word uses the start address unincremented.
- Exclusivity and pulse rules:
  - wr_en and rd_en are never high in the same cycle.
  - Each is at most one cycle per word.
- Reset (asynchronous, any time including mid-frame):
  - Outputs: MISO=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_abort=0.
  - Internal: state=IDLE, bitcnt=0, synchronisers=idle values (SSEL=1, SPI_CLK=CPOL).
  - After reset release, a frame already in progress is ignored until SSEL is seen high.
- SSEL asserted with no clocks, then deasserted: return to IDLE with no strobes and no frame_abort.

Test Plan:
- Read burst:
  - Stimulus: DATA_W=16, command 16'h8005, then 3 dummy words; model returns addr+16'h1000.
  - Required: MISO words 16'h4A53, 16'h1005, 16'h1006, 16'h1007; rd_addr sequence 5,6,7,8.
- Write burst with wrap:
  - Stimulus: command 16'h43FE, data 16'hAAAA, 16'h5555, 16'h1234.
  - Required: wr_en ×3 at addresses 0x3FE, 0x3FF, 0x000 with the matching data; no rd_en.
- Abort mid-word:
  - Stimulus: command 16'h4010, one full word 16'hBEEF, then 7 bits; SSEL rises.
  - Required: one wr_en (0x010, 16'hBEEF); one frame_abort pulse.
- No-op and idle:
  - Stimulus: command 16'h0000 plus 2 words; then SSEL low/high with no clocks.
  - Required: no rd_en/wr_en; MISO 0 after the ID word; no frame_abort.
- Reset mid-frame:
  - Stimulus: assert SYS_RST_N low during the second write word, then release; next frame write 16'h4020, 16'h0077.
  - Required: all outputs at reset values immediately; only wr_en at 0x020 with 16'h0077.
- CPOL=1:
  - Stimulus: repeat the read burst with idle-high SPI_CLK.
  - Required: identical MISO words and rd_addr sequence.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI slave bridging an external master to a single-cycle register rd/wr port.
// Command word selects read/write burst with auto-incrementing address; SPI inputs are resynchronised to SYS_CLK.
module spi_reg_bridge #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned ID_WORD = 16'h4A53,
  parameter bit          CPOL    = 1'b0
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST_N,
  input  logic              SPI_CLK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_abort
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ID_VAL   = DATA_W'(ID_WORD);

  typedef enum logic [2:0] {IDLE, CMD, RD, WR, SKIP} state_t;

  state_t state_q, state_d;

  logic [1:0]        sck_sync, ssel_sync, mosi_sync, valid_sr;
  logic              sck_d, ssel_d, armed;
  logic [CNT_W-1:0]  bitcnt;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] tx_sr, rx_word;
  logic [ADDR_W-1:0] addr, addr_inc, start_addr;
  logic [1:0]        op;
  logic              sck_in, active, lead, trail, word_done, ssel_fall, ssel_rise, load_q;

  assign sck_in     = SPI_CLK ^ CPOL;
  assign active     = (state_q != IDLE);
  assign lead       = active & sck_sync[1] & ~sck_d;
  assign trail      = active & ~sck_sync[1] & sck_d;
  assign ssel_fall  = armed & ~ssel_sync[1] & ssel_d;
  assign ssel_rise  = ssel_sync[1] & ~ssel_d;
  assign rx_word    = {rx_sr, mosi_sync[1]};
  assign word_done  = lead & (bitcnt == LAST_BIT);
  assign op         = rx_word[DATA_W-1 -: 2];
  assign start_addr = rx_word[ADDR_W-1:0];
  assign addr_inc   = addr + ADDR_W'(1);

  assign MISO = tx_sr[DATA_W-1];
  assign busy = active;

  // armed stays low until SSEL is genuinely seen high after reset, so a frame
  // already in flight at reset release is ignored.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      sck_sync  <= '0;
      sck_d     <= 1'b0;
      ssel_sync <= '1;
      ssel_d    <= 1'b1;
      mosi_sync <= '0;
      valid_sr  <= '0;
      armed     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge value, so the chain really is two stages.
      sck_sync  <= {sck_sync[0], sck_in};
      sck_d     <= sck_sync[1];
      ssel_sync <= {ssel_sync[0], SSEL};
      ssel_d    <= ssel_sync[1];
      mosi_sync <= {mosi_sync[0], MOSI};
      valid_sr  <= {valid_sr[0], 1'b1};
      armed     <= armed | (valid_sr[1] & ssel_sync[1]);
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ssel_fall) state_d = CMD;
      CMD: begin
        if (word_done) begin
          unique case (op)
            2'b10:   state_d = RD;
            2'b01:   state_d = WR;
            default: state_d = SKIP;
          endcase
        end
      end
      default: ;
    endcase
    if (active && ssel_rise) state_d = IDLE;
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      bitcnt      <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      addr        <= '0;
      load_q      <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_abort <= 1'b0;
    end else begin
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      frame_abort <= 1'b0;
      load_q      <= rd_en;
      if (!active) begin
        bitcnt <= '0;
        tx_sr  <= (state_d == CMD) ? ID_VAL : '0;
      end else if (ssel_rise) begin
        frame_abort <= (bitcnt != '0);
        bitcnt      <= '0;
        tx_sr       <= '0;
      end else begin
        if (lead) begin
          rx_sr  <= rx_word[DATA_W-2:0];
          bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + CNT_W'(1);
        end
        // No shift after the last bit: the next word's MSB must stay on MISO.
        if (trail && bitcnt != '0) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        if (load_q && state_q == RD) tx_sr <= rd_data;
        if (word_done) begin
          unique case (state_q)
            CMD: begin
              addr <= start_addr;
              if (op == 2'b10) begin
                rd_en   <= 1'b1;
                rd_addr <= start_addr;
              end else begin
                tx_sr <= '0;
              end
            end
            RD: begin
              addr    <= addr_inc;
              rd_en   <= 1'b1;
              rd_addr <= addr_inc;
            end
            WR: begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= rx_word;
              addr    <= addr_inc;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: one CPOL=0 and one CPOL=1 instance share SSEL/MOSI, the latter on inverted SPI_CLK.
module tb_spi_reg_bridge;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int HALF   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sck, ssel, mosi, sck_inv;
  logic miso0, miso1, rd_en0, rd_en1, wr_en0, wr_en1, busy0, busy1, ab0, ab1;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [DATA_W-1:0] rd_data0, rd_data1, wr_data0, wr_data1;

  assign sck_inv = ~sck;

  spi_reg_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_WORD(16'h4A53), .CPOL(1'b0)) dut0 (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .SPI_CLK(sck), .SSEL(ssel), .MOSI(mosi), .MISO(miso0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .wr_en(wr_en0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .busy(busy0), .frame_abort(ab0));

  spi_reg_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_WORD(16'h4A53), .CPOL(1'b1)) dut1 (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .SPI_CLK(sck_inv), .SSEL(ssel), .MOSI(mosi), .MISO(miso1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .busy(busy1), .frame_abort(ab1));

  // Register file model: read data is addr + 0x1000, one cycle after the address.
  always @(posedge clk) begin
    rd_data0 <= {6'b0, rd_addr0} + 16'h1000;
    rd_data1 <= {6'b0, rd_addr1} + 16'h1000;
  end

  logic [ADDR_W-1:0] rd0_log[64], rd1_log[64], wr0_alog[64];
  logic [DATA_W-1:0] wr0_dlog[64];
  int rd0_n = 0, rd1_n = 0, wr0_n = 0, wr1_n = 0, ab0_n = 0, ab1_n = 0, clash_n = 0;

  always @(negedge clk) begin
    if (rd_en0 === 1'b1) begin
      if (rd0_n < 64) rd0_log[rd0_n] = rd_addr0;
      rd0_n++;
    end
    if (rd_en1 === 1'b1) begin
      if (rd1_n < 64) rd1_log[rd1_n] = rd_addr1;
      rd1_n++;
    end
    if (wr_en0 === 1'b1) begin
      if (wr0_n < 64) begin
        wr0_alog[wr0_n] = wr_addr0;
        wr0_dlog[wr0_n] = wr_data0;
      end
      wr0_n++;
    end
    if (wr_en1 === 1'b1) wr1_n++;
    if (ab0 === 1'b1) ab0_n++;
    if (ab1 === 1'b1) ab1_n++;
    if ((rd_en0 & wr_en0) === 1'b1 || (rd_en1 & wr_en1) === 1'b1) clash_n++;
  end

  int n_checks = 0, n_fail = 0;
  logic [15:0] tx_q[8], rx0_q[8], rx1_q[8];

  task automatic spi_word(input logic [15:0] tx, input int nbits,
                          output logic [15:0] r0, output logic [15:0] r1);
    r0 = '0;
    r1 = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[15-i];
      repeat (HALF) @(negedge clk);
      r0 = {r0[14:0], miso0};
      r1 = {r1[14:0], miso1};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    ssel = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic run_frame(input int nwords);
    frame_start();
    for (int w = 0; w < nwords; w++) spi_word(tx_q[w], 16, rx0_q[w], rx1_q[w]);
    frame_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({miso0, rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0, busy0, ab0} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {miso0, rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0, busy0, ab0});
    end
    rst_n = 1'b1;
    repeat (4*HALF) @(negedge clk);
  endtask

  task automatic test_read_burst();
    logic [15:0] exp_m[4];
    int rb, wb;
    exp_m = '{16'h4A53, 16'h1005, 16'h1006, 16'h1007};
    rb = rd0_n;
    wb = wr0_n;
    tx_q[0] = 16'h8005;
    for (int i = 1; i < 4; i++) tx_q[i] = 16'h0000;
    run_frame(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx0_q[i] !== exp_m[i]) begin
        n_fail++;
        $display("FAIL read_miso[%0d]: got %h required %h", i, rx0_q[i], exp_m[i]);
      end
    end
    n_checks++;
    if (rd0_n - rb != 4) begin
      n_fail++;
      $display("FAIL read_rd_count: got %0d required 4", rd0_n - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd0_log[rb+i] !== ADDR_W'(5 + i)) begin
          n_fail++;
          $display("FAIL read_rd_addr[%0d]: got %h required %h", i, rd0_log[rb+i], 5 + i);
        end
      end
    end
    n_checks++;
    if (wr0_n != wb) begin
      n_fail++;
      $display("FAIL read_no_wr: got %0d writes required 0", wr0_n - wb);
    end
    n_checks++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_busy_after: got %b required 0", busy0);
    end
  endtask

  task automatic test_write_wrap();
    logic [ADDR_W-1:0] exp_a[3];
    logic [15:0] exp_d[3];
    int rb, wb;
    exp_a = '{10'h3FE, 10'h3FF, 10'h000};
    exp_d = '{16'hAAAA, 16'h5555, 16'h1234};
    rb = rd0_n;
    wb = wr0_n;
    tx_q[0] = 16'h43FE;
    for (int i = 0; i < 3; i++) tx_q[i+1] = exp_d[i];
    run_frame(4);
    n_checks++;
    if (wr0_n - wb != 3) begin
      n_fail++;
      $display("FAIL wrap_wr_count: got %0d required 3", wr0_n - wb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wr0_alog[wb+i] !== exp_a[i] || wr0_dlog[wb+i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL wrap_wr[%0d]: got %h/%h required %h/%h", i,
                   wr0_alog[wb+i], wr0_dlog[wb+i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_checks++;
    if (rd0_n != rb) begin
      n_fail++;
      $display("FAIL wrap_no_rd: got %0d reads required 0", rd0_n - rb);
    end
    n_checks++;
    if (rx0_q[0] !== 16'h4A53 || rx0_q[1] !== 16'h0 || rx0_q[3] !== 16'h0) begin
      n_fail++;
      $display("FAIL wrap_miso: got %h %h %h required 4a53 0000 0000", rx0_q[0], rx0_q[1], rx0_q[3]);
    end
  endtask

  task automatic test_abort();
    logic [15:0] r0, r1;
    int wb, ab;
    wb = wr0_n;
    ab = ab0_n;
    frame_start();
    spi_word(16'h4010, 16, r0, r1);
    spi_word(16'hBEEF, 16, r0, r1);
    spi_word(16'hFFFF, 7, r0, r1);
    frame_end();
    n_checks++;
    if (wr0_n - wb != 1) begin
      n_fail++;
      $display("FAIL abort_wr_count: got %0d required 1", wr0_n - wb);
    end else begin
      n_checks++;
      if (wr0_alog[wb] !== 10'h010 || wr0_dlog[wb] !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL abort_wr: got %h/%h required 010/beef", wr0_alog[wb], wr0_dlog[wb]);
      end
    end
    n_checks++;
    if (ab0_n - ab != 1) begin
      n_fail++;
      $display("FAIL abort_pulse: got %0d pulses required 1", ab0_n - ab);
    end
  endtask

  task automatic test_noop_idle();
    int rb, wb, ab;
    rb = rd0_n;
    wb = wr0_n;
    ab = ab0_n;
    tx_q[0] = 16'h0000;
    tx_q[1] = 16'hFFFF;
    tx_q[2] = 16'hA5A5;
    run_frame(3);
    n_checks++;
    if (rx0_q[0] !== 16'h4A53 || rx0_q[1] !== 16'h0 || rx0_q[2] !== 16'h0) begin
      n_fail++;
      $display("FAIL noop_miso: got %h %h %h required 4a53 0000 0000", rx0_q[0], rx0_q[1], rx0_q[2]);
    end
    ssel = 1'b0;
    repeat (2*HALF) @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_busy: got %b required 1", busy0);
    end
    ssel = 1'b1;
    repeat (2*HALF) @(negedge clk);
    n_checks++;
    if (rd0_n != rb || wr0_n != wb || ab0_n != ab || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL noop_strobes: got rd %0d wr %0d abort %0d busy %b required 0 0 0 0",
               rd0_n - rb, wr0_n - wb, ab0_n - ab, busy0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] r0, r1;
    int wb, ab;
    frame_start();
    spi_word(16'h4030, 16, r0, r1);
    spi_word(16'h1111, 8, r0, r1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({miso0, rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0, busy0, ab0} !== 41'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h required 0",
               {miso0, rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0, busy0, ab0});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wb = wr0_n;
    ab = ab0_n;
    spi_word(16'h1111, 8, r0, r1);
    spi_word(16'h2222, 16, r0, r1);
    frame_end();
    n_checks++;
    if (wr0_n != wb || ab0_n != ab) begin
      n_fail++;
      $display("FAIL midreset_ignored: got wr %0d abort %0d required 0 0", wr0_n - wb, ab0_n - ab);
    end
    tx_q[0] = 16'h4020;
    tx_q[1] = 16'h0077;
    run_frame(2);
    n_checks++;
    if (wr0_n - wb != 1) begin
      n_fail++;
      $display("FAIL midreset_wr_count: got %0d required 1", wr0_n - wb);
    end else begin
      n_checks++;
      if (wr0_alog[wb] !== 10'h020 || wr0_dlog[wb] !== 16'h0077) begin
        n_fail++;
        $display("FAIL midreset_wr: got %h/%h required 020/0077", wr0_alog[wb], wr0_dlog[wb]);
      end
    end
  endtask

  task automatic test_cpol1();
    logic [15:0] exp_m[4];
    int rb;
    exp_m = '{16'h4A53, 16'h1005, 16'h1006, 16'h1007};
    rb = rd1_n;
    tx_q[0] = 16'h8005;
    for (int i = 1; i < 4; i++) tx_q[i] = 16'h0000;
    run_frame(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx1_q[i] !== exp_m[i]) begin
        n_fail++;
        $display("FAIL cpol1_miso[%0d]: got %h required %h", i, rx1_q[i], exp_m[i]);
      end
    end
    n_checks++;
    if (rd1_n - rb != 4) begin
      n_fail++;
      $display("FAIL cpol1_rd_count: got %0d required 4", rd1_n - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd1_log[rb+i] !== ADDR_W'(5 + i)) begin
          n_fail++;
          $display("FAIL cpol1_rd_addr[%0d]: got %h required %h", i, rd1_log[rb+i], 5 + i);
        end
      end
    end
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (clash_n != 0) begin
      n_fail++;
      $display("FAIL rd_wr_exclusive: got %0d overlapping cycles required 0", clash_n);
    end
    n_checks++;
    if (ab1_n != ab0_n || wr1_n != wr0_n) begin
      n_fail++;
      $display("FAIL cpol_agree: got abort %0d/%0d wr %0d/%0d required equal", ab1_n, ab0_n, wr1_n, wr0_n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sck   = 1'b0;
    ssel  = 1'b1;
    mosi  = 1'b0;
    test_reset();
    test_read_burst();
    test_write_wrap();
    test_abort();
    test_noop_idle();
    test_reset_mid_frame();
    test_cpol1();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
